// File: rtl/slice_add_sequencer_if.sv
// -----------------------------------------------------------------------------
// slice_add_sequencer_if
//
// Purpose:
//   Bundles the operand-side and result-side valid/ready handshakes of
//   slice_add_sequencer into one interface.
//
// Signals:
//   in_valid  producer -> adder   a, b, cin (and sub) are valid
//   in_ready  adder -> producer   adder can accept operands
//   a, b      producer -> adder   WIDTH-bit addends
//   cin       producer -> adder   carry into slice 0
//   sub       producer -> adder   subtract request (only with SLICE_SUB_EN)
//   out_valid adder -> consumer   sum/cout are valid
//   out_ready consumer -> adder   consumer takes the result
//   sum       adder -> consumer   WIDTH-bit registered result
//   cout      adder -> consumer   registered carry out of the top slice
//   busy      adder -> observer   operation in flight (RUN or DONE)
//
// Modports:
//   slave  - the adder side
//   master - the producer/consumer side
//
// Optional macro SLICE_SUB_EN adds the sub signal.
// -----------------------------------------------------------------------------
interface slice_add_sequencer_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SLICE_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

`ifdef SLICE_SUB_EN
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
`else
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
`endif

endinterface

// File: rtl/slice_add_sequencer.sv
// -----------------------------------------------------------------------------
// slice_add_sequencer
//
// Purpose:
//   Multi-cycle WIDTH-bit adder built around a single SLICE-bit ripple-carry
//   slice. Operands are captured once, then one slice is added per clock,
//   LSB first, with the inter-slice carry kept in a register. The result is
//   presented with a valid/ready handshake and held until taken.
//
// Parameters:
//   WIDTH  operand/result width, integer multiple of SLICE
//   SLICE  adder slice width, >= 1
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slice_add_sequencer_if.slave: operand handshake (in_valid,
//          in_ready, a, b, cin), result handshake (out_valid, out_ready,
//          sum, cout) and busy status
//
// Optional macro:
//   SLICE_SUB_EN  adds bus.sub; when set at acceptance the adder computes
//                 a - b (b inverted, carry seeded with 1, cin ignored) and
//                 cout=1 means no borrow.
//
// Timing:
//   Accepting edge enters RUN; NSLICES RUN cycles; the last RUN edge enters
//   DONE where out_valid is high. One operation per NSLICES+2 cycles.
// -----------------------------------------------------------------------------
module slice_add_sequencer #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  slice_add_sequencer_if.slave  bus
);

  // Guard the division so a bad SLICE still reaches the error below
  localparam int NSLICES = (SLICE > 0) ? (WIDTH / SLICE) : 1;
  localparam int IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;

  generate
    if (SLICE < 1) begin : g_bad_slice
      $error("slice_add_sequencer: SLICE must be at least 1");
    end else if ((WIDTH % SLICE) != 0) begin : g_bad_width
      $error("slice_add_sequencer: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_carry;
  logic [IDXW-1:0]   r_idx;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_busy;
  logic              w_accept;
  logic              w_run;
  logic              w_last;

  logic [SLICE-1:0]  w_a_slice;
  logic [SLICE-1:0]  w_b_slice;
  logic [SLICE-1:0]  w_s;
  logic [SLICE:0]    w_c;

  logic [WIDTH-1:0]  w_b_load;
  logic              w_carry_seed;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;
  assign w_run    = (r_state == S_RUN);
  assign w_last   = (r_idx == IDXW'(NSLICES - 1));

  // ---------------------------------------------------------------------------
  // Operand conditioning at capture time
  // ---------------------------------------------------------------------------
`ifdef SLICE_SUB_EN
  // Two's-complement subtract: a + ~b + 1. cin is ignored when subtracting.
  assign w_b_load     = bus.sub ? ~bus.b : bus.b;
  assign w_carry_seed = bus.sub ? 1'b1   : bus.cin;
`else
  assign w_b_load     = bus.b;
  assign w_carry_seed = bus.cin;
`endif

  // ---------------------------------------------------------------------------
  // Current slice operands
  // ---------------------------------------------------------------------------
  assign w_a_slice = r_a[r_idx*SLICE +: SLICE];
  assign w_b_slice = r_b[r_idx*SLICE +: SLICE];

  // ---------------------------------------------------------------------------
  // SLICE-bit ripple-carry adder, one full adder per bit
  // ---------------------------------------------------------------------------
  assign w_c[0] = r_carry;

  generate
    for (genvar gi = 0; gi < SLICE; gi++) begin : g_fa
      logic w_p;
      assign w_p       = w_a_slice[gi] ^ w_b_slice[gi];
      assign w_s[gi]   = w_p ^ w_c[gi];
      assign w_c[gi+1] = (w_a_slice[gi] & w_b_slice[gi]) | (w_p & w_c[gi]);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Operand, carry, index and carry-out registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= w_b_load;
      r_carry <= w_carry_seed;
      r_idx   <= '0;
    end else if (w_run) begin
      r_carry <= w_c[SLICE];
      // Past the last slice the index value is don't-care; it is cleared
      // again on the next acceptance.
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_c[SLICE];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result register: only the slice addressed by r_idx is written each RUN
  // cycle, so the previous result persists outside RUN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (w_run) begin
      for (int i = 0; i < NSLICES; i++) begin
        if (r_idx == IDXW'(i)) begin
          r_sum[i*SLICE +: SLICE] <= w_s;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Interface outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;

endmodule
